// File: rtl/stream_addr_rule_pkg.sv
// rtl/stream_addr_rule_pkg.sv - shared types for the routing-rule table controller
package stream_addr_rule_pkg;

   typedef enum logic [1:0] {
      CFG_MASK  = 2'd0,
      CFG_BASE  = 2'd1,
      CFG_SLAVE = 2'd2
   } cfg_field_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      SWAP  = 2'd2
   } ctrl_state_e;

   // Index width that stays legal (>=1 bit) even for a single-entry space
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_txn_counter.sv
// rtl/stream_txn_counter.sv - saturating outstanding-transaction counter
module stream_txn_counter #(
   parameter  int unsigned MaxTxns  = 8,
   localparam int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                inc_i,
   input  logic                dec_i,
   output logic [CntWidth-1:0] count_o,
   output logic                full_o,
   output logic                empty_o
);

   logic [CntWidth-1:0] count_q;
   logic                up;
   logic                dn;

   assign full_o  = (count_q == CntWidth'(MaxTxns));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   // A completion with nothing outstanding is dropped rather than wrapping
   assign up = inc_i && !full_o;
   assign dn = dec_i && !empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         case ({up, dn})
            2'b10:   count_q <= count_q + CntWidth'(1);
            2'b01:   count_q <= count_q - CntWidth'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   underflow_chk : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec_i && empty_o));

endmodule

// File: rtl/stream_addr_rule_ctrl.sv
// rtl/stream_addr_rule_ctrl.sv - shadow/active rule table with drain-then-swap commit
module stream_addr_rule_ctrl
   import stream_addr_rule_pkg::*;
#(
   parameter  int unsigned NrOutput     = 2,
   parameter  int unsigned AddressWidth = 32,
   parameter  int unsigned NrRules      = 4,
   parameter  int unsigned MaxTxns      = 8,
   localparam int unsigned LogNrOutput  = clog2_min1(NrOutput),
   localparam int unsigned CfgIdxWidth  = clog2_min1(NrRules),
   localparam int unsigned CntWidth     = $clog2(MaxTxns + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            cfg_valid_i,
   output logic                            cfg_ready_o,
   input  logic [CfgIdxWidth-1:0]          cfg_idx_i,
   input  logic [1:0]                      cfg_field_i,
   input  logic [AddressWidth-1:0]         cfg_data_i,
   input  logic                            commit_valid_i,
   output logic                            commit_ready_o,
   input  logic                            inp_valid_i,
   output logic                            inp_ready_o,
   output logic                            gated_valid_o,
   input  logic                            gated_ready_i,
   input  logic                            txn_done_i,
   output logic [NrRules*AddressWidth-1:0] addr_mask_o,
   output logic [NrRules*AddressWidth-1:0] addr_base_o,
   output logic [NrRules*LogNrOutput-1:0]  addr_slave_o,
   output logic                            busy_o
);

   ctrl_state_e state_q, state_d;

   logic [AddressWidth-1:0] shadow_mask_q [NrRules];
   logic [AddressWidth-1:0] shadow_base_q [NrRules];
   logic [LogNrOutput-1:0]  shadow_slave_q[NrRules];
   logic [AddressWidth-1:0] active_mask_q [NrRules];
   logic [AddressWidth-1:0] active_base_q [NrRules];
   logic [LogNrOutput-1:0]  active_slave_q[NrRules];

   logic [CntWidth-1:0] cnt_count;
   logic                cnt_full;
   logic                cnt_empty;
   logic                gate_open;
   logic                drain_done;
   logic                cfg_fire;

   // Gate depends only on state and count, never on inp_valid_i
   assign gate_open     = (state_q == IDLE) && !cnt_full;
   assign gated_valid_o = gate_open && inp_valid_i;
   assign inp_ready_o   = gate_open && gated_ready_i;
   assign busy_o        = (state_q != IDLE);

   stream_txn_counter #(
      .MaxTxns (MaxTxns)
   ) u_txn_counter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (gated_valid_o && gated_ready_i),
      .dec_i   (txn_done_i),
      .count_o (cnt_count),
      .full_o  (cnt_full),
      .empty_o (cnt_empty)
   );

   // The gate is closed while draining, so the last completion empties the counter
   assign drain_done = cnt_empty || ((cnt_count == CntWidth'(1)) && txn_done_i);

   always_comb begin
      state_d        = state_q;
      commit_ready_o = 1'b0;
      cfg_ready_o    = 1'b1;
      case (state_q)
         IDLE:    if (commit_valid_i) state_d = DRAIN;
         DRAIN:   if (drain_done) state_d = SWAP;
         SWAP: begin
            commit_ready_o = 1'b1;
            cfg_ready_o    = 1'b0;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   assign cfg_fire = cfg_valid_i && cfg_ready_o;

   // Out-of-range indices match no entry and unknown fields hit the default arm
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NrRules; i++) begin
            shadow_mask_q[i]  <= '0;
            shadow_base_q[i]  <= '0;
            shadow_slave_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NrRules; i++) begin
            if (cfg_fire && (cfg_idx_i == CfgIdxWidth'(i))) begin
               case (cfg_field_i)
                  CFG_MASK:  shadow_mask_q[i]  <= cfg_data_i;
                  CFG_BASE:  shadow_base_q[i]  <= cfg_data_i;
                  CFG_SLAVE: shadow_slave_q[i] <= cfg_data_i[LogNrOutput-1:0];
                  default:   ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NrRules; i++) begin
            active_mask_q[i]  <= '0;
            active_base_q[i]  <= '0;
            active_slave_q[i] <= '0;
         end
      end else if (state_q == SWAP) begin
         for (int i = 0; i < NrRules; i++) begin
            active_mask_q[i]  <= shadow_mask_q[i];
            active_base_q[i]  <= shadow_base_q[i];
            active_slave_q[i] <= shadow_slave_q[i];
         end
      end
   end

   for (genvar g = 0; g < NrRules; g++) begin : g_flatten
      assign addr_mask_o[g*AddressWidth +: AddressWidth] = active_mask_q[g];
      assign addr_base_o[g*AddressWidth +: AddressWidth] = active_base_q[g];
      assign addr_slave_o[g*LogNrOutput +: LogNrOutput]  = active_slave_q[g];
   end

   commit_hold_chk : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q != IDLE) |-> commit_valid_i);

endmodule
